cache_ctrl: RTL and testbench
=============================

# cache_ctrl

Cache controller FSM sitting directly upstream of the direct-mapped cache line array. It accepts single-word CPU read/write requests, runs lookup through the array, and on a miss writes back a dirty victim line and refills the line from main memory word by word using the array's store/edit controls. The controller is write-back and write-allocate, and it runs on the posedge of `clk`. The array samples on the negedge.

## Interface
- `TAG_BITS`, 22, tag width; must match the array.
- `LINE_WORDS`, 4, words per line.
- `LINE_WORDS_WIDTH`, 2, word-offset width (log2 `LINE_WORDS`).
- Local constants: `ADDR_BITS` = 32, word = 32 bits, byte offset = 2 bits, index = `ADDR_BITS-TAG_BITS-LINE_WORDS_WIDTH-2`.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: reset, synchronous, active-low.
- `cpu_req` in 1: request; held high until `cpu_ack`.
- `cpu_we` in 1: 1 = write, 0 = read; stable while `cpu_req` is high.
- `cpu_addr` in 32: word address; bits [1:0] are ignored.
- `cpu_din` in 32: write data.
- `cpu_dout` out 32: read data, valid while `cpu_ack` is high.
- `cpu_ack` out 1: one-cycle completion pulse.
- `cache_addr` out 32: array address.
- `cache_store` out 1: array store strobe.
- `cache_edit` out 1: array edit strobe.
- `cache_invalid` out 1: array invalidate; tied 0.
- `cache_din` out 32: array write data.
- `cache_hit` in 1: from the array.
- `cache_dout` in 32: from the array.
- `cache_valid` in 1: from the array.
- `cache_dirty` in 1: from the array.
- `cache_tag` in TAG_BITS: from the array.
- `mem_cs` out 1: memory request.
- `mem_we` out 1: 1 = memory write.
- `mem_addr` out 32: memory word address.
- `mem_din` out 32: data to memory.
- `mem_dout` in 32: data from memory.
- `mem_ack` in 1: memory completion, sampled at posedge.

## Operation
- States: IDLE, LOOKUP, COMPARE, WB_READ, WB_WRITE, AL_READ, AL_STORE.
- Registers:
  - latched request (`addr`, `we`, `din`);
  - `victim_tag`;
  - 2-bit word counter `wc`;
  - refill buffer.
- IDLE:
  - Accepts a request when `cpu_req`=1 and `cpu_ack`=0.
  - Latches the request and goes to LOOKUP.
- LOOKUP:
  - `cache_addr` = latched address.
  - The array registers `valid`/`dirty`/`tag`/`dout` at the mid-cycle negedge.
  - Next state is COMPARE.
- COMPARE (`cache_addr` unchanged; `cache_hit` is stable for the whole cycle):
  - Read hit: `cpu_dout` <= `cache_dout`, `cpu_ack` <= 1, go to IDLE.
  - Write hit: `cache_edit`=1 and `cache_din`=latched din for this cycle only, `cpu_ack` <= 1, go to IDLE.
  - Miss with `cache_valid` & `cache_dirty`: `victim_tag` <= `cache_tag`, `wc` <= 0, go to WB_READ.
  - Miss, otherwise: `wc` <= 0, go to AL_READ.
- WB_READ:
  - `cache_addr` = {`victim_tag`, index, `wc`, 2'b00}.
  - `mem_cs`=0.
  - Next state is WB_WRITE.
- WB_WRITE:
  - `cache_addr` is held.
  - `mem_cs`=1, `mem_we`=1, `mem_addr` = same victim word address, `mem_din` = `cache_dout`.
  - Outputs are held until `mem_ack`=1 is sampled.
  - On `mem_ack`: `wc`++; if `wc` was `LINE_WORDS-1`, go to AL_READ with `wc`=0; else go to WB_READ.
- AL_READ:
  - `mem_cs`=1, `mem_we`=0, `mem_addr` = {latched tag, index, `wc`, 2'b00}.
  - Outputs are held until `mem_ack`.
  - On `mem_ack`: buffer <= `mem_dout`, go to AL_STORE.
- AL_STORE (one cycle):
  - `cache_addr` = refill word address, `cache_store`=1, `cache_din` = buffer, `mem_cs`=0.
  - `wc`++.
  - If `wc` was `LINE_WORDS-1`, go to LOOKUP (re-lookup, which now hits); else go to AL_READ.
- A write miss completes through the post-refill COMPARE write-hit path, so the line ends dirty.
- Word counter wraps modulo `LINE_WORDS`; no carry into the index.
- `cache_store` and `cache_edit` are never both 1.
- `mem_cs` is never high outside WB_WRITE and AL_READ.

## Timing
- Reset (`rst`=0 at posedge):
  - State = IDLE, `wc`=0.
  - `cpu_ack`=0, `cpu_dout`=0, `mem_cs`=0, `mem_we`=0, `cache_store`=0, `cache_edit`=0, `cache_invalid`=0, all address/data outputs 0.
  - Reset mid-transfer abandons it; `mem_cs` is low in the first cycle after the reset edge.
  - A partially refilled line may remain valid; software must not rely on it.
- The array's own active-high reset is driven from ~`rst` at top level.
- Hit latency: request sampled at edge E0; `cpu_ack` is high in the cycle after E2 (3 cycles).
- Memory with ack in the first `mem_cs` cycle:
  - Clean miss: 13 cycles (ack after E12).
  - Dirty miss: 21 cycles.
  - Each extra memory wait cycle adds 1 per word.
- `cpu_ack` is exactly one cycle wide.
- `cpu_req` still high during the ack cycle is not re-accepted.
- `mem_ack` outside WB_WRITE/AL_READ is ignored.

## Test plan
- Reset values: hold `rst`=0 for 3 cycles with `cpu_req`=1.
  - All outputs are 0 and no `mem_cs`.
  - Release `rst`; a request is accepted at the next edge.
- Cold read: read 0x0000_0040.
  - Exactly 4 memory reads at 0x40, 0x44, 0x48, 0x4C, with 4 `cache_store` pulses.
  - `cpu_dout` = memory word at 0x40.
  - Ack at cycle 13.
- Read hit after the cold read: read 0x0000_0048.
  - No `mem_cs`; ack at cycle 3 with the 0x48 data.
- Write hit: write 0xDEADBEEF to 0x44.
  - One `cache_edit` cycle, ack at cycle 3.
  - A subsequent read of 0x44 returns 0xDEADBEEF.
- Dirty eviction: after the write hit, read 0x0000_1040 (same index, different tag).
  - 4 memory writes at 0x40–0x4C; the 0x44 write carries 0xDEADBEEF.
  - Then 4 reads at 0x1040–0x104C.
  - Ack at cycle 21.
- Memory wait states plus reset: `mem_ack` delayed 3 cycles per word.
  - Latency grows by 12 on a clean miss.
  - Assert `rst`=0 during the second AL_READ: `mem_cs` drops next cycle, FSM is in IDLE, no `cpu_ack`.

Source files
------------

// File: rtl/cache_ctrl_if.sv
// Bundle of CPU, cache-array and main-memory signals around the cache controller.
// The controller takes the master view; the CPU/array/memory side takes the slave view.
interface cache_ctrl_if #(
    parameter int TAG_BITS = 22
);
    logic                cpu_req;
    logic                cpu_we;
    logic [31:0]         cpu_addr;
    logic [31:0]         cpu_din;
    logic [31:0]         cpu_dout;
    logic                cpu_ack;

    logic [31:0]         cache_addr;
    logic                cache_store;
    logic                cache_edit;
    logic                cache_invalid;
    logic [31:0]         cache_din;
    logic                cache_hit;
    logic [31:0]         cache_dout;
    logic                cache_valid;
    logic                cache_dirty;
    logic [TAG_BITS-1:0] cache_tag;

    logic                mem_cs;
    logic                mem_we;
    logic [31:0]         mem_addr;
    logic [31:0]         mem_din;
    logic [31:0]         mem_dout;
    logic                mem_ack;

    modport master (
        input  cpu_req, cpu_we, cpu_addr, cpu_din,
        output cpu_dout, cpu_ack,
        output cache_addr, cache_store, cache_edit, cache_invalid, cache_din,
        input  cache_hit, cache_dout, cache_valid, cache_dirty, cache_tag,
        output mem_cs, mem_we, mem_addr, mem_din,
        input  mem_dout, mem_ack
    );

    modport slave (
        output cpu_req, cpu_we, cpu_addr, cpu_din,
        input  cpu_dout, cpu_ack,
        input  cache_addr, cache_store, cache_edit, cache_invalid, cache_din,
        output cache_hit, cache_dout, cache_valid, cache_dirty, cache_tag,
        input  mem_cs, mem_we, mem_addr, mem_din,
        output mem_dout, mem_ack
    );
endinterface

// File: rtl/cache_ctrl.sv
// Write-back, write-allocate controller for a direct-mapped line array that samples on negedge.
// Misses write back a dirty victim word by word, refill the line, then re-run the lookup.
module cache_ctrl #(
    parameter int TAG_BITS         = 22,
    parameter int LINE_WORDS       = 4,
    parameter int LINE_WORDS_WIDTH = 2
) (
    input  logic          clk,
    input  logic          rst,
    cache_ctrl_if.master  bus
);
    localparam int ADDR_BITS = 32;
    localparam int IDX_BITS  = ADDR_BITS - TAG_BITS - LINE_WORDS_WIDTH - 2;

    typedef enum logic [2:0] {IDLE, LOOKUP, COMPARE, WB_READ, WB_WRITE, AL_READ, AL_STORE} state_t;
    typedef logic [LINE_WORDS_WIDTH-1:0] wc_t;
    localparam wc_t WC_LAST = wc_t'(LINE_WORDS - 1);

    state_t                state_q;
    logic [ADDR_BITS-1:0]  addr_q;
    logic [31:0]           din_q;
    logic                  we_q;
    logic [TAG_BITS-1:0]   victim_tag_q;
    wc_t                   wc_q;

    logic [31:0]           cpu_dout_q;
    logic                  cpu_ack_q;
    logic [ADDR_BITS-1:0]  cache_addr_q;
    logic                  cache_store_q;
    logic                  cache_edit_q;
    logic [31:0]           cache_din_q;
    logic                  mem_cs_q;
    logic                  mem_we_q;
    logic [ADDR_BITS-1:0]  mem_addr_q;
    logic [31:0]           mem_din_q;

    logic [TAG_BITS-1:0]   req_tag;
    logic [IDX_BITS-1:0]   req_idx;
    wc_t                   wc_inc;

    assign req_tag = addr_q[ADDR_BITS-1 -: TAG_BITS];
    assign req_idx = addr_q[ADDR_BITS-TAG_BITS-1 -: IDX_BITS];
    assign wc_inc  = wc_q + wc_t'(1);

    function automatic logic [ADDR_BITS-1:0] line_word(input logic [TAG_BITS-1:0] tag,
                                                       input logic [IDX_BITS-1:0] idx,
                                                       input wc_t w);
        return {tag, idx, w, 2'b00};
    endfunction

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            din_q         <= '0;
            we_q          <= 1'b0;
            victim_tag_q  <= '0;
            wc_q          <= '0;
            cpu_dout_q    <= '0;
            cpu_ack_q     <= 1'b0;
            cache_addr_q  <= '0;
            cache_store_q <= 1'b0;
            cache_edit_q  <= 1'b0;
            cache_din_q   <= '0;
            mem_cs_q      <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_din_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    cpu_ack_q <= 1'b0;
                    if (bus.cpu_req && !cpu_ack_q) begin
                        addr_q       <= bus.cpu_addr & 32'hFFFF_FFFC;
                        cache_addr_q <= bus.cpu_addr & 32'hFFFF_FFFC;
                        we_q         <= bus.cpu_we;
                        din_q        <= bus.cpu_din;
                        state_q      <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    // Hit is already valid after the array's mid-cycle sample, so the
                    // edit strobe can be registered to land exactly in COMPARE.
                    cache_edit_q <= we_q & bus.cache_hit;
                    cache_din_q  <= din_q;
                    state_q      <= COMPARE;
                end
                COMPARE: begin
                    cache_edit_q <= 1'b0;
                    wc_q         <= '0;
                    if (bus.cache_hit) begin
                        if (!we_q) cpu_dout_q <= bus.cache_dout;
                        cpu_ack_q <= 1'b1;
                        state_q   <= IDLE;
                    end else if (bus.cache_valid && bus.cache_dirty) begin
                        victim_tag_q <= bus.cache_tag;
                        cache_addr_q <= line_word(bus.cache_tag, req_idx, '0);
                        state_q      <= WB_READ;
                    end else begin
                        mem_cs_q   <= 1'b1;
                        mem_we_q   <= 1'b0;
                        mem_addr_q <= line_word(req_tag, req_idx, '0);
                        state_q    <= AL_READ;
                    end
                end
                WB_READ: begin
                    mem_cs_q   <= 1'b1;
                    mem_we_q   <= 1'b1;
                    mem_addr_q <= cache_addr_q;
                    mem_din_q  <= bus.cache_dout;
                    state_q    <= WB_WRITE;
                end
                WB_WRITE: begin
                    if (bus.mem_ack) begin
                        wc_q <= wc_inc;
                        if (wc_q == WC_LAST) begin
                            mem_we_q   <= 1'b0;
                            mem_addr_q <= line_word(req_tag, req_idx, '0);
                            state_q    <= AL_READ;
                        end else begin
                            mem_cs_q     <= 1'b0;
                            mem_we_q     <= 1'b0;
                            cache_addr_q <= line_word(victim_tag_q, req_idx, wc_inc);
                            state_q      <= WB_READ;
                        end
                    end
                end
                AL_READ: begin
                    if (bus.mem_ack) begin
                        // cache_din doubles as the refill word buffer
                        cache_din_q   <= bus.mem_dout;
                        cache_store_q <= 1'b1;
                        cache_addr_q  <= line_word(req_tag, req_idx, wc_q);
                        mem_cs_q      <= 1'b0;
                        state_q       <= AL_STORE;
                    end
                end
                AL_STORE: begin
                    cache_store_q <= 1'b0;
                    wc_q          <= wc_inc;
                    if (wc_q == WC_LAST) begin
                        cache_addr_q <= addr_q;
                        state_q      <= LOOKUP;
                    end else begin
                        mem_cs_q   <= 1'b1;
                        mem_we_q   <= 1'b0;
                        mem_addr_q <= line_word(req_tag, req_idx, wc_inc);
                        state_q    <= AL_READ;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.cpu_dout      = cpu_dout_q;
    assign bus.cpu_ack       = cpu_ack_q;
    assign bus.cache_addr    = cache_addr_q;
    assign bus.cache_store   = cache_store_q;
    assign bus.cache_edit    = cache_edit_q;
    assign bus.cache_invalid = 1'b0;
    assign bus.cache_din     = cache_din_q;
    assign bus.mem_cs        = mem_cs_q;
    assign bus.mem_we        = mem_we_q;
    assign bus.mem_addr      = mem_addr_q;
    assign bus.mem_din       = mem_din_q;
endmodule

// File: tb/tb_cache_ctrl.sv
// Bench for cache_ctrl: negedge line-array model, wait-state memory model, directed vector
// table, randomized traffic against a flat-memory reference, and reset-mid-refill sequence.
module tb_cache_ctrl;
    localparam int TAG_BITS = 22;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    cache_ctrl_if #(.TAG_BITS(TAG_BITS)) bus ();

    cache_ctrl #(.TAG_BITS(TAG_BITS), .LINE_WORDS(4), .LINE_WORDS_WIDTH(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_err    = 0;
    int mem_wait = 0;

    function automatic logic [31:0] initw(input logic [31:0] a);
        return (a * 32'h0100_0193) ^ 32'h5A5A_1234;
    endfunction

    // ---------------- direct-mapped line array model (negedge) ----------------
    logic [31:0] arr_data  [0:255];
    logic [21:0] arr_tag   [0:63];
    logic        arr_valid [0:63] = '{default: 1'b0};
    logic        arr_dirty [0:63] = '{default: 1'b0};
    logic        a_valid = 1'b0;
    logic        a_dirty = 1'b0;
    logic [21:0] a_tag   = '0;
    logic [31:0] a_dout  = '0;
    int          n_store = 0;
    int          n_edit  = 0;
    int          n_both  = 0;
    logic [5:0]  c_idx;
    logic [7:0]  c_slot;
    logic [21:0] c_tag;

    assign c_idx  = bus.cache_addr[9:4];
    assign c_slot = bus.cache_addr[9:2];
    assign c_tag  = bus.cache_addr[31:10];
    assign bus.cache_hit   = a_valid && (a_tag == c_tag);
    assign bus.cache_valid = a_valid;
    assign bus.cache_dirty = a_dirty;
    assign bus.cache_tag   = a_tag;
    assign bus.cache_dout  = a_dout;

    always @(negedge clk) begin
        if (bus.cache_store) begin
            arr_data[c_slot] <= bus.cache_din;
            arr_tag[c_idx]   <= c_tag;
            arr_valid[c_idx] <= 1'b1;
            arr_dirty[c_idx] <= 1'b0;
        end else if (bus.cache_edit) begin
            arr_data[c_slot] <= bus.cache_din;
            arr_dirty[c_idx] <= 1'b1;
        end
        a_valid <= bus.cache_store | arr_valid[c_idx];
        a_dirty <= bus.cache_store ? 1'b0 : (bus.cache_edit | arr_dirty[c_idx]);
        a_tag   <= bus.cache_store ? c_tag : arr_tag[c_idx];
        a_dout  <= (bus.cache_store | bus.cache_edit) ? bus.cache_din : arr_data[c_slot];
        n_store <= n_store + (bus.cache_store ? 1 : 0);
        n_edit  <= n_edit + (bus.cache_edit ? 1 : 0);
        n_both  <= n_both + ((bus.cache_store && bus.cache_edit) ? 1 : 0);
    end

    // ---------------- main memory model with wait states ----------------
    logic [31:0] mem_wd   [0:4095];
    logic        mem_flag [0:4095] = '{default: 1'b0};
    logic [31:0] log_addr [0:31];
    logic        log_we   [0:31];
    logic [31:0] log_data [0:31];
    int          n_log = 0;
    int          mcnt  = 0;
    int          m_cur;
    logic [11:0] m_slot;

    assign m_slot = bus.mem_addr[13:2];
    assign m_cur  = (bus.mem_ack === 1'b1) ? 0 : mcnt;

    always @(negedge clk) begin
        if (bus.mem_cs !== 1'b1) begin
            bus.mem_ack <= 1'b0;
            mcnt        <= 0;
        end else if (m_cur >= mem_wait) begin
            bus.mem_ack  <= 1'b1;
            mcnt         <= 0;
            bus.mem_dout <= mem_flag[m_slot] ? mem_wd[m_slot] : initw(bus.mem_addr);
            if (bus.mem_we) begin
                mem_wd[m_slot]   <= bus.mem_din;
                mem_flag[m_slot] <= 1'b1;
            end
            log_addr[n_log % 32] <= bus.mem_addr;
            log_we[n_log % 32]   <= bus.mem_we;
            log_data[n_log % 32] <= bus.mem_we ? bus.mem_din : 32'h0;
            n_log                <= n_log + 1;
        end else begin
            bus.mem_ack <= 1'b0;
            mcnt        <= m_cur + 1;
        end
    end

    // ---------------- reference model: CPU-visible memory + line bookkeeping ----------------
    logic        ref_valid [0:63] = '{default: 1'b0};
    logic        ref_dirty [0:63] = '{default: 1'b0};
    logic [21:0] ref_tag   [0:63];
    logic [31:0] ref_d     [0:4095];
    logic        ref_f     [0:4095] = '{default: 1'b0};

    function automatic int model_lat(input logic [31:0] a, input int w);
        if (ref_valid[a[9:4]] && ref_tag[a[9:4]] == a[31:10]) return 3;
        if (ref_valid[a[9:4]] && ref_dirty[a[9:4]]) return 21 + 8 * w;
        return 13 + 4 * w;
    endfunction

    task automatic ref_apply(input logic we, input logic [31:0] a, input logic [31:0] d,
                             output logic [31:0] exp_d);
        if (ref_valid[a[9:4]] && ref_tag[a[9:4]] == a[31:10]) begin
            ref_dirty[a[9:4]] = ref_dirty[a[9:4]] | we;
        end else begin
            ref_valid[a[9:4]] = 1'b1;
            ref_tag[a[9:4]]   = a[31:10];
            ref_dirty[a[9:4]] = we;
        end
        if (we) begin
            ref_d[a[13:2]] = d;
            ref_f[a[13:2]] = 1'b1;
        end
        exp_d = ref_f[a[13:2]] ? ref_d[a[13:2]] : initw(a);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic count_log(input int base, output int nrd, output int nwr);
        nrd = 0;
        nwr = 0;
        for (int k = base; k < n_log; k++) begin
            if (log_we[k % 32]) nwr++;
            else nrd++;
        end
    endtask

    // Called #1 after a posedge; the next posedge samples the request.
    task automatic do_req(input logic we, input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] dout, output int lat);
        bus.cpu_req  = 1'b1;
        bus.cpu_we   = we;
        bus.cpu_addr = a;
        bus.cpu_din  = d;
        lat  = 0;
        dout = '0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (bus.cpu_ack === 1'b1) break;
        end
        if (bus.cpu_ack !== 1'b1) begin
            n_checks++;
            n_err++;
            $display("FAIL ack_timeout: addr %h got no cpu_ack expected ack within 400 cycles", a);
            lat = -1;
        end else begin
            dout = bus.cpu_dout;
            @(posedge clk);
            #1;
            check("ack_width", {31'b0, bus.cpu_ack}, 32'h0);
        end
        bus.cpu_req = 1'b0;
    endtask

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] din;
        logic [31:0] exp_dout;
        int          exp_lat;
        int          exp_rd;
        int          exp_wr;
        int          exp_store;
        int          exp_edit;
    } vec_t;

    vec_t vt [0:6];
    int   vbase [0:6];

    initial begin
        int          lat, nrd, nwr, b_store, b_edit, el, found;
        logic [31:0] d, ed, a;
        logic        we;

        vt[0] = '{1'b0, 32'h0000_0040, 32'h0, initw(32'h40),   13, 4, 0, 4, 0};
        vt[1] = '{1'b0, 32'h0000_0048, 32'h0, initw(32'h48),    3, 0, 0, 0, 0};
        vt[2] = '{1'b1, 32'h0000_0044, 32'hDEAD_BEEF, 32'h0,    3, 0, 0, 0, 1};
        vt[3] = '{1'b0, 32'h0000_0044, 32'h0, 32'hDEAD_BEEF,    3, 0, 0, 0, 0};
        vt[4] = '{1'b0, 32'h0000_1040, 32'h0, initw(32'h1040), 21, 4, 4, 4, 0};
        vt[5] = '{1'b1, 32'h0000_2050, 32'h1234_5678, 32'h0,   13, 4, 0, 4, 1};
        vt[6] = '{1'b0, 32'h0000_2050, 32'h0, 32'h1234_5678,    3, 0, 0, 0, 0};

        // Reset held with a pending request.
        bus.cpu_req  = 1'b1;
        bus.cpu_we   = 1'b0;
        bus.cpu_addr = 32'h40;
        bus.cpu_din  = 32'h0;
        rst          = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            check($sformatf("rst%0d_mem_cs", c), {31'b0, bus.mem_cs}, 32'h0);
            check($sformatf("rst%0d_cpu_ack", c), {31'b0, bus.cpu_ack}, 32'h0);
        end
        check("rst_cpu_dout", bus.cpu_dout, 32'h0);
        check("rst_mem_we", {31'b0, bus.mem_we}, 32'h0);
        check("rst_store_edit_inv", {29'b0, bus.cache_store, bus.cache_edit, bus.cache_invalid}, 32'h0);
        check("rst_cache_addr", bus.cache_addr, 32'h0);
        check("rst_cache_din", bus.cache_din, 32'h0);
        check("rst_mem_addr", bus.mem_addr, 32'h0);
        check("rst_mem_din", bus.mem_din, 32'h0);
        rst = 1'b1;

        // Directed vector table.
        mem_wait = 0;
        for (int i = 0; i < 7; i++) begin
            ref_apply(vt[i].we, vt[i].addr, vt[i].din, ed);
            vbase[i] = n_log;
            b_store  = n_store;
            b_edit   = n_edit;
            do_req(vt[i].we, vt[i].addr, vt[i].din, d, lat);
            count_log(vbase[i], nrd, nwr);
            check($sformatf("v%0d_latency", i), lat, vt[i].exp_lat);
            if (!vt[i].we) check($sformatf("v%0d_dout", i), d, vt[i].exp_dout);
            check($sformatf("v%0d_mem_reads", i), nrd, vt[i].exp_rd);
            check($sformatf("v%0d_mem_writes", i), nwr, vt[i].exp_wr);
            check($sformatf("v%0d_stores", i), n_store - b_store, vt[i].exp_store);
            check($sformatf("v%0d_edits", i), n_edit - b_edit, vt[i].exp_edit);
            $display("vec %0d we=%0d addr=%h dout=%h latency=%0d", i, vt[i].we, vt[i].addr, d, lat);
        end

        // Memory traffic order for the cold read and the dirty eviction.
        for (int k = 0; k < 4; k++) begin
            check($sformatf("cold_rd%0d_addr", k), log_addr[(vbase[0] + k) % 32], 32'h40 + 32'(4 * k));
            check($sformatf("evict_wr%0d_addr", k), log_addr[(vbase[4] + k) % 32], 32'h40 + 32'(4 * k));
            check($sformatf("evict_wr%0d_we", k), {31'b0, log_we[(vbase[4] + k) % 32]}, 32'h1);
            check($sformatf("evict_wr%0d_data", k), log_data[(vbase[4] + k) % 32],
                  (k == 1) ? 32'hDEAD_BEEF : initw(32'h40 + 32'(4 * k)));
            check($sformatf("evict_rd%0d_addr", k), log_addr[(vbase[4] + 4 + k) % 32], 32'h1040 + 32'(4 * k));
        end

        // Randomized traffic over a few conflicting tags and indices, random wait states.
        for (int t = 0; t < 60; t++) begin
            a  = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(2, 7)) << 4) |
                 (32'($urandom_range(0, 3)) << 2);
            we = 1'($urandom_range(0, 1));
            mem_wait = $urandom_range(0, 2);
            el = model_lat(a, mem_wait);
            d  = $urandom;
            ref_apply(we, a, d, ed);
            do_req(we, a, d, d, lat);
            check($sformatf("rnd%0d_latency", t), lat, el);
            if (!we) check($sformatf("rnd%0d_dout", t), d, ed);
            $display("rnd %0d we=%0d addr=%h wait=%0d latency=%0d", t, we, a, mem_wait, lat);
        end

        // Three wait cycles per word on a clean miss.
        mem_wait = 3;
        ref_apply(1'b0, 32'h0000_0A80, 32'h0, ed);
        do_req(1'b0, 32'h0000_0A80, 32'h0, d, lat);
        check("wait_latency", lat, 25);
        check("wait_dout", d, initw(32'hA80));
        $display("wait addr=%h dout=%h latency=%0d", 32'hA80, d, lat);

        // Reset during the second AL_READ of a refill.
        b_store      = n_store;
        bus.cpu_req  = 1'b1;
        bus.cpu_we   = 1'b0;
        bus.cpu_addr = 32'h0000_0F20;
        found        = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            if (n_store - b_store == 1 && bus.mem_cs === 1'b1) begin
                found = 1;
                break;
            end
        end
        check("second_al_read_seen", found, 1);
        rst         = 1'b0;
        bus.cpu_req = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_mem_cs", {31'b0, bus.mem_cs}, 32'h0);
        check("midrst_cpu_ack", {31'b0, bus.cpu_ack}, 32'h0);
        check("midrst_store", {31'b0, bus.cache_store}, 32'h0);
        rst = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            check($sformatf("postrst%0d_idle", c), {30'b0, bus.mem_cs, bus.cpu_ack}, 32'h0);
        end
        $display("reset mid-refill addr=%h abandoned", 32'hF20);

        // Controller accepts fresh work after the abandoned refill.
        mem_wait = 0;
        el = model_lat(32'h0000_0048, 0);
        ref_apply(1'b0, 32'h0000_0048, 32'h0, ed);
        do_req(1'b0, 32'h0000_0048, 32'h0, d, lat);
        check("postrst_latency", lat, el);
        check("postrst_dout", d, ed);
        $display("post-reset addr=%h dout=%h latency=%0d", 32'h48, d, lat);

        check("store_edit_overlap", n_both, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end
endmodule
